adc_serial_readout: RTL and testbench

- Parametrised controller for a multi-lane serial SAR ADC with BUSY handshake; generalises the current fixed 2-lane CNVST/BUSY/SCLK/DOUTA/DOUTB interface to N lanes.
- Adds three things: programmable SCLK rate, a continuous-acquisition mode, and power-of-two hardware averaging with a BUSY timeout.
- Sits between the ADC pins and the pipe-out FIFO logic in TOP; one result word per lane per completed average.

---
 rtl/adc_serial_readout.sv | 251 +++++++++++++++++++++++++
 tb/tb_adc_serial_readout.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_readout.sv
// Multi-lane serial SAR ADC readout controller.
// Runs the CNVST / BUSY / SCLK handshake, shifts N_CH lanes in parallel and
// averages 2^avg_log2 conversions per result. Optional continuous re-trigger.
// A stuck BUSY edge aborts the acquisition and raises a sticky error flag.
module adc_serial_readout #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned CNV_W    = 4,
    parameter int unsigned BUSY_TO  = 255,
    parameter int unsigned AVG_MAX  = 3
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic                     cont,
    input  logic [2:0]               avg_log2,
    output logic                     CNVST,
    output logic                     CS,
    output logic                     SCLK,
    input  logic                     BUSY,
    input  logic [N_CH-1:0]          DOUT,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic                     valid,
    output logic                     active,
    output logic                     timeout_err
);

    localparam int unsigned ACC_W   = DATA_W + AVG_MAX;
    localparam int unsigned CNV_CW  = $clog2(CNV_W + 1);
    localparam int unsigned DIV_CW  = $clog2(SCLK_DIV + 1);
    localparam int unsigned BIT_CW  = $clog2(DATA_W + 1);
    localparam int unsigned TO_CW   = $clog2(BUSY_TO + 1);
    localparam int unsigned NCONV_W = AVG_MAX + 1;
    localparam logic [2:0]  AVG_CLAMP = 3'(AVG_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SHIFT,
        S_ACC,
        S_OUT
    } state_t;

    state_t                    r_state;
    logic                      r_busy_s1;
    logic                      r_busy_s2;
    logic [2:0]                r_avg;
    logic [CNV_CW-1:0]         r_cnv_cnt;
    logic [TO_CW-1:0]          r_hi_cnt;
    logic [TO_CW-1:0]          r_lo_cnt;
    logic [DIV_CW-1:0]         r_div_cnt;
    logic [BIT_CW-1:0]         r_bit_cnt;
    logic [NCONV_W-1:0]        r_conv_cnt;
    logic signed [DATA_W-1:0]  r_shreg [N_CH];
    logic signed [ACC_W-1:0]   r_acc   [N_CH];
    logic                      r_cnvst;
    logic                      r_cs;
    logic                      r_sclk;
    logic [N_CH*DATA_W-1:0]    r_data_out;
    logic                      r_valid;
    logic                      r_active;
    logic                      r_timeout_err;

    logic signed [ACC_W-1:0]   w_acc_sum [N_CH];
    logic [N_CH*DATA_W-1:0]    w_avg_word;
    logic [NCONV_W-1:0]        w_conv_next;
    logic [NCONV_W-1:0]        w_conv_target;
    logic [2:0]                w_avg_clamped;

    assign CNVST       = r_cnvst;
    assign CS          = r_cs;
    assign SCLK        = r_sclk;
    assign data_out    = r_data_out;
    assign valid       = r_valid;
    assign active      = r_active;
    assign timeout_err = r_timeout_err;

    // Two-flop synchroniser for the asynchronous BUSY pin.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_busy_s1 <= 1'b0;
            r_busy_s2 <= 1'b0;
        end else begin
            r_busy_s1 <= BUSY;
            r_busy_s2 <= r_busy_s1;
        end
    end

    // Per-lane accumulate-with-sample and floor-average of the updated sum.
    always_comb begin
        w_avg_word    = '0;
        w_avg_clamped = (avg_log2 > AVG_CLAMP) ? AVG_CLAMP : avg_log2;
        w_conv_next   = r_conv_cnt + NCONV_W'(1);
        w_conv_target = NCONV_W'(1) << r_avg;
        for (int i = 0; i < N_CH; i++) begin
            w_acc_sum[i] = r_acc[i] + ACC_W'(r_shreg[i]);
            w_avg_word[i*DATA_W +: DATA_W] = DATA_W'(w_acc_sum[i] >>> r_avg);
        end
    end

    // Acquisition FSM with registered pin and result outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_avg         <= '0;
            r_cnv_cnt     <= '0;
            r_hi_cnt      <= '0;
            r_lo_cnt      <= '0;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_conv_cnt    <= '0;
            r_cnvst       <= 1'b1;
            r_cs          <= 1'b1;
            r_sclk        <= 1'b1;
            r_data_out    <= '0;
            r_valid       <= 1'b0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_shreg[i] <= '0;
                r_acc[i]   <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_avg         <= w_avg_clamped;
                        r_timeout_err <= 1'b0;
                        r_conv_cnt    <= '0;
                        r_cnv_cnt     <= '0;
                        r_cnvst       <= 1'b0;
                        r_active      <= 1'b1;
                        r_state       <= S_CNV;
                        for (int i = 0; i < N_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end

                S_CNV: begin
                    if (r_cnv_cnt == CNV_CW'(CNV_W - 1)) begin
                        r_cnvst  <= 1'b1;
                        r_hi_cnt <= '0;
                        r_state  <= S_WAIT_HI;
                    end else begin
                        r_cnv_cnt <= r_cnv_cnt + CNV_CW'(1);
                    end
                end

                S_WAIT_HI: begin
                    if (r_busy_s2) begin
                        r_lo_cnt <= '0;
                        r_state  <= S_WAIT_LO;
                    end else if (r_hi_cnt == TO_CW'(BUSY_TO - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_active      <= 1'b0;
                        r_state       <= S_IDLE;
                        for (int i = 0; i < N_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else begin
                        r_hi_cnt <= r_hi_cnt + TO_CW'(1);
                    end
                end

                S_WAIT_LO: begin
                    if (!r_busy_s2) begin
                        r_sclk    <= 1'b0;
                        r_cs      <= 1'b0;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end else if (r_lo_cnt == TO_CW'(BUSY_TO - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_active      <= 1'b0;
                        r_state       <= S_IDLE;
                        for (int i = 0; i < N_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else begin
                        r_lo_cnt <= r_lo_cnt + TO_CW'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_div_cnt == DIV_CW'(SCLK_DIV - 1)) begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            // Rising SCLK edge: capture current bit on every lane.
                            r_sclk <= 1'b1;
                            for (int i = 0; i < N_CH; i++) begin
                                r_shreg[i] <= {r_shreg[i][DATA_W-2:0], DOUT[i]};
                            end
                            if (r_bit_cnt == BIT_CW'(DATA_W - 1)) begin
                                r_cs    <= 1'b1;
                                r_state <= S_ACC;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                            end
                        end else begin
                            r_sclk <= 1'b0;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_CW'(1);
                    end
                end

                S_ACC: begin
                    r_conv_cnt <= w_conv_next;
                    for (int i = 0; i < N_CH; i++) begin
                        r_acc[i] <= w_acc_sum[i];
                    end
                    if (w_conv_next == w_conv_target) begin
                        r_data_out <= w_avg_word;
                        r_valid    <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_cnv_cnt <= '0;
                        r_cnvst   <= 1'b0;
                        r_state   <= S_CNV;
                    end
                end

                S_OUT: begin
                    if (cont) begin
                        r_conv_cnt <= '0;
                        r_cnv_cnt  <= '0;
                        r_cnvst    <= 1'b0;
                        r_state    <= S_CNV;
                        for (int i = 0; i < N_CH; i++) begin
                            r_acc[i] <= '0;
                        end
                    end else begin
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_readout.sv
// Directed bench for adc_serial_readout: default 2-lane instance plus a
// 4-lane / 18-bit / slower-SCLK instance, each driven by a small ADC model.
module tb_adc_serial_readout;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_start, a_cont, a_cnvst, a_cs, a_sclk, a_busy, a_valid, a_active, a_to;
    logic [2:0]  a_avg;
    logic [1:0]  a_dout;
    logic [31:0] a_data;

    // Instance B: 4 lanes, 18 bits, SCLK_DIV=3
    logic        b_start, b_cont, b_cnvst, b_cs, b_sclk, b_busy, b_valid, b_active, b_to;
    logic [2:0]  b_avg;
    logic [3:0]  b_dout;
    logic [71:0] b_data;

    adc_serial_readout #(
        .N_CH(2), .DATA_W(16), .SCLK_DIV(2), .CNV_W(4), .BUSY_TO(255), .AVG_MAX(3)
    ) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .start(a_start), .cont(a_cont), .avg_log2(a_avg),
        .CNVST(a_cnvst), .CS(a_cs), .SCLK(a_sclk), .BUSY(a_busy), .DOUT(a_dout),
        .data_out(a_data), .valid(a_valid), .active(a_active), .timeout_err(a_to)
    );

    adc_serial_readout #(
        .N_CH(4), .DATA_W(18), .SCLK_DIV(3), .CNV_W(4), .BUSY_TO(255), .AVG_MAX(3)
    ) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .start(b_start), .cont(b_cont), .avg_log2(b_avg),
        .CNVST(b_cnvst), .CS(b_cs), .SCLK(b_sclk), .BUSY(b_busy), .DOUT(b_dout),
        .data_out(b_data), .valid(b_valid), .active(b_active), .timeout_err(b_to)
    );

    int n_err = 0;
    int n_checks = 0;

    // ---------------- ADC model A ----------------
    logic [15:0] a_seq [2][8];
    int   a_idx = 0, a_cur = 0, a_bit = 0;
    bit   a_busy_en = 1'b1;
    int   a_vcnt = 0, a_pulses = 0, a_rise = 0, a_lrun = 0, a_low_last = 0;
    logic [31:0] a_last = '0;
    logic a_cnvst_q = 1'b1, a_sclk_q = 1'b1, a_cs_q = 1'b1;

    always begin
        @(negedge a_cnvst);
        if (a_busy_en) begin
            repeat (3) @(negedge clk);
            a_busy = 1'b1;
            repeat (10) @(negedge clk);
            a_cur  = a_idx % 8;
            a_idx++;
            a_bit  = 15;
            a_dout = {a_seq[1][a_cur][15], a_seq[0][a_cur][15]};
            a_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (a_valid === 1'b1) begin a_vcnt++; a_last = a_data; end
        if (a_cnvst === 1'b0) a_lrun++;
        else if (a_lrun != 0) begin a_low_last = a_lrun; a_lrun = 0; end
        if (a_cnvst === 1'b0 && a_cnvst_q === 1'b1) begin a_pulses++; a_rise = 0; end
        if (a_sclk === 1'b1 && a_sclk_q === 1'b0 && a_cs_q === 1'b0) a_rise++;
        if (a_sclk === 1'b0 && a_sclk_q === 1'b1 && a_cs === 1'b0 && a_rise > 0 && a_bit > 0) begin
            a_bit--;
            a_dout = {a_seq[1][a_cur][a_bit], a_seq[0][a_cur][a_bit]};
        end
        a_cnvst_q = a_cnvst; a_sclk_q = a_sclk; a_cs_q = a_cs;
    end

    // ---------------- ADC model B ----------------
    logic [17:0] b_seq [4][8];
    int   b_idx = 0, b_cur = 0, b_bit = 0;
    int   b_vcnt = 0, b_pulses = 0, b_rise = 0, b_slo = 0, b_shi = 0, b_slo_last = 0, b_shi_last = 0;
    logic [71:0] b_last = '0;
    logic b_cnvst_q = 1'b1, b_sclk_q = 1'b1, b_cs_q = 1'b1;

    always begin
        @(negedge b_cnvst);
        repeat (3) @(negedge clk);
        b_busy = 1'b1;
        repeat (10) @(negedge clk);
        b_cur = b_idx % 8;
        b_idx++;
        b_bit = 17;
        for (int i = 0; i < 4; i++) b_dout[i] = b_seq[i][b_cur][17];
        b_busy = 1'b0;
    end

    always @(negedge clk) begin
        if (b_valid === 1'b1) begin b_vcnt++; b_last = b_data; end
        if (b_cnvst === 1'b0 && b_cnvst_q === 1'b1) begin b_pulses++; b_rise = 0; end
        if (b_sclk === 1'b1 && b_sclk_q === 1'b0 && b_cs_q === 1'b0) b_rise++;
        if (b_cs === 1'b0 && b_sclk === 1'b0) b_slo++;
        else if (b_slo != 0) begin b_slo_last = b_slo; b_slo = 0; end
        if (b_cs === 1'b0 && b_sclk === 1'b1) b_shi++;
        else if (b_shi != 0) begin b_shi_last = b_shi; b_shi = 0; end
        if (b_sclk === 1'b0 && b_sclk_q === 1'b1 && b_cs === 1'b0 && b_rise > 0 && b_bit > 0) begin
            b_bit--;
            for (int i = 0; i < 4; i++) b_dout[i] = b_seq[i][b_cur][b_bit];
        end
        b_cnvst_q = b_cnvst; b_sclk_q = b_sclk; b_cs_q = b_cs;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input int k, input logic [15:0] l0, input logic [15:0] l1);
        a_seq[0][k] = l0;
        a_seq[1][k] = l1;
    endtask

    task automatic pulse_a();
        a_start = 1'b1; tick(); a_start = 1'b0;
    endtask

    task automatic wait_a_idle(input string tag);
        int k;
        k = 0;
        while (a_active !== 1'b0 && k < 20000) begin tick(); k++; end
        chk(tag, 128'(k < 20000), 128'(1));
    endtask

    int v0, p0, k;

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_cont = 1'b0; a_avg = 3'd0; a_busy = 1'b0; a_dout = '0;
        b_start = 1'b0; b_cont = 1'b0; b_avg = 3'd0; b_busy = 1'b0; b_dout = '0;
        for (int i = 0; i < 8; i++) begin
            set_a(i, 16'h0000, 16'h0000);
            b_seq[0][i] = 18'h1FFFF;
            b_seq[1][i] = 18'h20000;
            b_seq[2][i] = 18'(i);
            b_seq[3][i] = -18'(i + 1);
        end
        repeat (3) tick();

        // Reset values
        chk("rst_cnvst", 128'(a_cnvst), 128'(1));
        chk("rst_cs", 128'(a_cs), 128'(1));
        chk("rst_sclk", 128'(a_sclk), 128'(1));
        chk("rst_data", 128'(a_data), 128'(0));
        chk("rst_valid", 128'(a_valid), 128'(0));
        chk("rst_active", 128'(a_active), 128'(0));
        chk("rst_timeout", 128'(a_to), 128'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Single conversion
        set_a(0, 16'h1234, 16'hFEDC);
        a_idx = 0; v0 = a_vcnt; a_avg = 3'd0;
        pulse_a();
        chk("single_active_hi", 128'(a_active), 128'(1));
        wait_a_idle("single_done");
        chk("single_vcnt", 128'(a_vcnt - v0), 128'(1));
        chk("single_data", 128'(a_last), 128'(32'hFEDC1234));
        chk("single_cnvst_width", 128'(a_low_last), 128'(4));
        chk("single_sclk_rises", 128'(a_rise), 128'(16));
        chk("single_active_lo", 128'(a_active), 128'(0));

        // Averaging, positive: (100+101+102+104)/4 = 101, (0+1+2+3)/4 = 1
        set_a(0, 16'd100, 16'd0); set_a(1, 16'd101, 16'd1);
        set_a(2, 16'd102, 16'd2); set_a(3, 16'd104, 16'd3);
        a_idx = 0; v0 = a_vcnt; p0 = a_pulses; a_avg = 3'd2;
        pulse_a();
        wait_a_idle("avg_pos_done");
        chk("avg_pos_vcnt", 128'(a_vcnt - v0), 128'(1));
        chk("avg_pos_convs", 128'(a_pulses - p0), 128'(4));
        chk("avg_pos_lane0", 128'(a_last[15:0]), 128'(16'd101));
        chk("avg_pos_lane1", 128'(a_last[31:16]), 128'(16'd1));

        // Averaging, signed floor: -7/4 -> -2, (3-4)/4 -> -1
        set_a(0, 16'hFFFF, 16'h0003); set_a(1, 16'hFFFE, 16'hFFFC);
        set_a(2, 16'hFFFE, 16'h0000); set_a(3, 16'hFFFE, 16'h0000);
        a_idx = 0; v0 = a_vcnt;
        pulse_a();
        wait_a_idle("avg_neg_done");
        chk("avg_neg_vcnt", 128'(a_vcnt - v0), 128'(1));
        chk("avg_neg_lane0", 128'(a_last[15:0]), 128'(16'hFFFE));
        chk("avg_neg_lane1", 128'(a_last[31:16]), 128'(16'hFFFF));

        // Continuous mode: 5 results, drop cont mid-conversion, one more result
        for (int i = 0; i < 8; i++) set_a(i, 16'h0100 + 16'(i), 16'h8000 + 16'(i));
        a_idx = 0; v0 = a_vcnt; a_avg = 3'd0; a_cont = 1'b1;
        pulse_a();
        k = 0;
        while (a_vcnt - v0 < 5 && k < 5000) begin tick(); k++; end
        chk("cont_five_results", 128'(k < 5000), 128'(1));
        repeat (10) tick();
        a_cont = 1'b0;
        wait_a_idle("cont_done");
        chk("cont_vcnt", 128'(a_vcnt - v0), 128'(6));
        chk("cont_last_data", 128'(a_last), 128'(32'h80050105));
        p0 = a_pulses;
        repeat (200) tick();
        chk("cont_no_more_cnvst", 128'(a_pulses - p0), 128'(0));
        chk("cont_idle", 128'(a_active), 128'(0));

        // BUSY timeout: BUSY never rises
        a_busy_en = 1'b0; v0 = a_vcnt; a_avg = 3'd0;
        pulse_a();
        k = 0;
        while (a_cnvst !== 1'b1 && k < 100) begin tick(); k++; end
        k = 0;
        while (a_to !== 1'b1 && k < 1000) begin tick(); k++; end
        chk("to_delay", 128'(k), 128'(255));
        chk("to_flag", 128'(a_to), 128'(1));
        chk("to_no_valid", 128'(a_vcnt - v0), 128'(0));
        chk("to_idle", 128'(a_active), 128'(0));
        a_busy_en = 1'b1;
        set_a(0, 16'h5A5A, 16'h0001);
        a_idx = 0; v0 = a_vcnt;
        pulse_a();
        chk("to_cleared_by_start", 128'(a_to), 128'(0));
        wait_a_idle("to_retry_done");
        chk("to_retry_data", 128'(a_last), 128'(32'h00015A5A));

        // Reset in the middle of SHIFT
        set_a(0, 16'hC3C3, 16'h3C3C);
        a_idx = 0;
        pulse_a();
        k = 0;
        while (a_rise < 7 && k < 500) begin tick(); k++; end
        chk("rst_mid_reach_bit7", 128'(k < 500), 128'(1));
        chk("rst_mid_cs_low", 128'(a_cs), 128'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_cnvst", 128'(a_cnvst), 128'(1));
        chk("rst_mid_cs", 128'(a_cs), 128'(1));
        chk("rst_mid_sclk", 128'(a_sclk), 128'(1));
        chk("rst_mid_data", 128'(a_data), 128'(0));
        chk("rst_mid_valid", 128'(a_valid), 128'(0));
        chk("rst_mid_active", 128'(a_active), 128'(0));
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        set_a(0, 16'h7FFF, 16'h8000);
        a_idx = 0; v0 = a_vcnt;
        pulse_a();
        wait_a_idle("rst_fresh_done");
        chk("rst_fresh_vcnt", 128'(a_vcnt - v0), 128'(1));
        chk("rst_fresh_data", 128'(a_last), 128'(32'h80007FFF));

        // Parametric instance: avg_log2=5 clamps to 3 -> 8 conversions
        b_idx = 0; v0 = b_vcnt; p0 = b_pulses; b_avg = 3'd5;
        b_start = 1'b1; tick(); b_start = 1'b0;
        k = 0;
        while (b_active !== 1'b0 && k < 20000) begin tick(); k++; end
        chk("par_done", 128'(k < 20000), 128'(1));
        chk("par_vcnt", 128'(b_vcnt - v0), 128'(1));
        chk("par_convs", 128'(b_pulses - p0), 128'(8));
        chk("par_sclk_low", 128'(b_slo_last), 128'(3));
        chk("par_sclk_high", 128'(b_shi_last), 128'(3));
        chk("par_sclk_rises", 128'(b_rise), 128'(18));
        chk("par_lane0", 128'(b_last[17:0]), 128'(18'h1FFFF));
        chk("par_lane1", 128'(b_last[35:18]), 128'(18'h20000));
        chk("par_lane2", 128'(b_last[53:36]), 128'(18'd3));
        chk("par_lane3", 128'(b_last[71:54]), 128'(18'h3FFFB));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
